// File: rtl/jk_pkg.sv
// Shared types and per-bit J/K excitation for the JK bank write driver.
// Optional build macro: JK_TOGGLE_EN selects toggle encoding instead of set/reset.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } drv_state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;

  // Returns {j,k} that moves one JK bit from q to tgt in a single clock.
  function automatic logic [1:0] jk_encode(input logic q, input logic tgt);
    logic [1:0] jk;
    jk = JK_HOLD;
    if (q != tgt) begin
`ifdef JK_TOGGLE_EN
      jk = 2'b11;
`else
      jk = {tgt, q};
`endif
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// Combinational WIDTH-wide J/K excitation encoder built from jk_encode.
module jk_excite_enc
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      {j[i], k[i]} = jk_encode(q[i], tgt[i]);
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Write-side controller: drives a JK bank to a requested word, verifies it, retries a bounded number of times.
// Build option: define JK_TOGGLE_EN for toggle excitation (see jk_pkg).
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  drv_state_e       state;
  logic [RW-1:0]    retry_cnt;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] enc_tgt;
  logic [WIDTH-1:0] enc_j;
  logic [WIDTH-1:0] enc_k;

  // j/k are registered, so the excitation is computed one edge early: from the
  // incoming word on accept, from the latched target on a retry.
  assign enc_tgt = (state == IDLE) ? tgt_data : tgt_q;

  jk_excite_enc #(.WIDTH(WIDTH)) u_enc (
    .q   (q_fb),
    .tgt (enc_tgt),
    .j   (enc_j),
    .k   (enc_k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      retry_cnt <= '0;
      tgt_q     <= '0;
      j         <= '0;
      k         <= '0;
      tgt_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      j    <= '0;
      k    <= '0;
      unique case (state)
        IDLE: begin
          if (tgt_valid && tgt_ready) begin
            tgt_q     <= tgt_data;
            retry_cnt <= '0;
            j         <= enc_j;
            k         <= enc_k;
            tgt_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: state <= CHECK;
        CHECK: begin
          if (q_fb == tgt_q) begin
            done      <= 1'b1;
            tgt_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            j         <= enc_j;
            k         <= enc_k;
            state     <= DRIVE;
          end else begin
            err       <= 1'b1;
            tgt_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          tgt_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
